// File: rtl/pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and shifts it out MSB first on w.
// Optional continuous resend is enabled with `define PATTERN_TX_REPEAT_EN; the port is named rpt since repeat is a reserved word.
module pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WIDTH-1:0]             pattern,
  input  logic [$clog2(WIDTH+1)-1:0]   len,
  input  logic                         rpt,
  output logic                         w,
  output logic                         valid,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   State
);

  localparam int LW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] pat;
  logic [LW-1:0]    lenq;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    leff;
  logic [LW-1:0]    shamt;
  logic [WIDTH-1:0] aligned;
  logic             accept;
  logic             last;
  logic             rep_go;

`ifdef PATTERN_TX_REPEAT_EN
  assign rep_go = rpt;
`else
  logic unused_rpt;
  assign unused_rpt = rpt;
  assign rep_go     = 1'b0;
`endif

  assign leff   = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign shamt  = LW'(WIDTH) - leff;
  // Left-justify the pattern so the bit to send is always sr[WIDTH-1].
  assign aligned = pattern << shamt;
  assign accept  = start && (len != '0);
  assign last    = (cnt == LW'(1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (last) state_n = rep_go ? SHIFT : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      pat   <= '0;
      lenq  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept) begin
            sr   <= aligned;
            pat  <= aligned;
            lenq <= leff;
            cnt  <= leff;
          end
        end
        SHIFT: begin
          // A repeated pass reloads from the latched copy, not from the inputs.
          if (last && rep_go) begin
            sr  <= pat;
            cnt <= lenq;
          end else begin
            sr  <= sr << 1;
            cnt <= cnt - LW'(1);
          end
        end
        default: begin
          sr  <= sr;
          cnt <= cnt;
        end
      endcase
    end
  end

  assign valid = (state == SHIFT);
  assign w     = valid & sr[WIDTH-1];
  assign done  = (state == DONE);
  assign busy  = (state != IDLE);
  assign State = state;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: queue-based expected-output model plus directed literal checks.
module tb_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       rpt;
  logic       w, valid, busy, done;
  logic [1:0] State;

  int errors = 0;
  int checks = 0;

  pattern_tx #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .rpt(rpt), .w(w), .valid(valid), .busy(busy), .done(done), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic       v;
    logic       d;
    logic       last;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  logic armed = 1'b0;
  logic [7:0] mpat;
  int mlen;

  function automatic exp_t mk(input logic bw, input logic bv, input logic bd,
                              input logic bl, input logic [1:0] bs);
    exp_t e;
    e.w = bw; e.v = bv; e.d = bd; e.last = bl; e.st = bs;
    return e;
  endfunction

  task automatic push_pass();
    for (int k = 0; k < mlen; k++)
      q.push_back(mk(mpat[mlen-1-k], 1'b1, 1'b0, k == mlen-1, 2'b01));
  endtask

  // Expected outputs for the cycle following each edge: a queue of future cycles.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      cur = '0;
      armed = 1'b1;
    end else begin
      if (cur.st == 2'b00 && start && len != 0) begin
        mpat = pattern;
        mlen = (len > 8) ? 8 : int'(len);
        push_pass();
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
      end
`ifdef PATTERN_TX_REPEAT_EN
      if (cur.last && rpt) begin
        q.delete();
        push_pass();
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
      end
`endif
      cur = (q.size() > 0) ? q.pop_front() : '0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed)
      chk("cycle {w,valid,busy,done,State}",
          16'({w, valid, busy, done, State}),
          16'({cur.w, cur.v, cur.st != 2'b00, cur.d, cur.st}));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] l, input int cycles,
                      output logic [15:0] bits, output int nvalid, output int ndone);
    tick();
    pattern = p; len = l; start = 1'b1;
    tick();
    start = 1'b0;
    bits = '0; nvalid = 0; ndone = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        bits = {bits[14:0], w};
        nvalid++;
      end
      if (done === 1'b1) ndone++;
    end
  endtask

  logic [15:0] bits;
  int nv, nd;

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; len = '0; rpt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset", 16'({w, valid, busy, done, State}), 16'h0000);

    send(8'b1011_0010, 4'd8, 11, bits, nv, nd);
    chk("pat8_bits", bits, 16'h00B2);
    chk("pat8_nvalid", 16'(nv), 16'd8);
    chk("pat8_done", 16'(nd), 16'd1);

    send(8'hFF, 4'd3, 6, bits, nv, nd);
    chk("len3_bits", bits, 16'h0007);
    chk("len3_nvalid", 16'(nv), 16'd3);
    chk("len3_done", 16'(nd), 16'd1);

    send(8'hFF, 4'd0, 5, bits, nv, nd);
    chk("len0_nvalid", 16'(nv), 16'd0);
    chk("len0_done", 16'(nd), 16'd0);

    send(8'h5C, 4'd12, 11, bits, nv, nd);
    chk("len12_bits", bits, 16'h005C);
    chk("len12_nvalid", 16'(nv), 16'd8);

    send(8'h81, 4'd1, 4, bits, nv, nd);
    chk("len1_bits", bits, 16'h0001);
    chk("len1_done", 16'(nd), 16'd1);

    // Reset on the 4th bit of an 8-bit transfer.
    tick();
    pattern = 8'hA5; len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 16'({w, valid, busy, done, State}), 16'h0000);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("midreset_no_done", 16'(nd), 16'd0);

`ifdef PATTERN_TX_REPEAT_EN
    tick();
    pattern = 8'b0000_1100; len = 4'd4; start = 1'b1; rpt = 1'b1;
    tick();
    start = 1'b0;
    bits = '0; nv = 0; nd = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (nv >= 8) rpt = 1'b0;
      if (valid === 1'b1) begin bits = {bits[14:0], w}; nv++; end
      if (done === 1'b1) nd++;
    end
    chk("repeat_bits", bits, 16'h0CCC);
    chk("repeat_nvalid", 16'(nv), 16'd12);
    chk("repeat_done", 16'(nd), 16'd1);
`endif

    // Randomized traffic: start may land in any state; model decides acceptance.
    for (int i = 0; i < 3000; i++) begin
      tick();
      start   = ($urandom_range(0, 2) == 0);
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      rpt     = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 99) == 0);
    end
    tick();
    start = 1'b0; reset = 1'b0; rpt = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
